// File: rtl/tnn_pkg.sv
// Shared encodings and state type for the ternary neuron datapath.
package tnn_pkg;

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_NEG  = 2'b11;
    localparam logic [1:0] ACT_ZERO = 2'b00;

    localparam int PC_MAX_DEFAULT = 25;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } state_t;

endpackage

// File: rtl/tnn_act_compare.sv
// Two-threshold ternary activation on a signed sum; +1 wins when the thresholds overlap.
module tnn_act_compare
    import tnn_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic signed [ACC_W-1:0] i_sum,
    input  logic signed [ACC_W-1:0] i_thr_hi,
    input  logic signed [ACC_W-1:0] i_thr_lo,
    output logic        [1:0]       o_act
);

    // Priority compare: high threshold checked first
    always_comb begin
        o_act = ACT_ZERO;
        if (i_sum >= i_thr_hi) begin
            o_act = ACT_POS;
        end else if (i_sum <= i_thr_lo) begin
            o_act = ACT_NEG;
        end else begin
            o_act = ACT_ZERO;
        end
    end

endmodule

// File: rtl/ternary_neuron_accum.sv
// Accumulates CHUNKS clamped popcount differences and emits a registered ternary activation
// through a valid/ready handshake.
module ternary_neuron_accum
    import tnn_pkg::*;
#(
    parameter int CHUNKS = 4,
    parameter int PC_W   = 5,
    parameter int PC_MAX = PC_MAX_DEFAULT,
    parameter int ACC_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [PC_W-1:0]  pc_pos,
    input  logic        [PC_W-1:0]  pc_neg,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [1:0]       out_act,
    output logic signed [ACC_W-1:0] out_sum
);

    localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [PC_W-1:0]  PC_MAX_L = PC_MAX[PC_W-1:0];
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHUNKS - 1);

    state_t                    r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic        [CNT_W-1:0]   r_cnt;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic        [1:0]         r_out_act;
    logic signed [ACC_W-1:0]   r_out_sum;

    logic        [PC_W-1:0]    w_pos_cl;
    logic        [PC_W-1:0]    w_neg_cl;
    logic signed [ACC_W-1:0]   w_pos_ext;
    logic signed [ACC_W-1:0]   w_neg_ext;
    logic signed [ACC_W-1:0]   w_d;
    logic signed [ACC_W-1:0]   w_sum_next;
    logic        [1:0]         w_act;
    logic                      w_last;

    // Clamp approximate popcounts and form the signed chunk contribution
    always_comb begin
        w_pos_cl   = (pc_pos > PC_MAX_L) ? PC_MAX_L : pc_pos;
        w_neg_cl   = (pc_neg > PC_MAX_L) ? PC_MAX_L : pc_neg;
        w_pos_ext  = {{(ACC_W-PC_W){1'b0}}, w_pos_cl};
        w_neg_ext  = {{(ACC_W-PC_W){1'b0}}, w_neg_cl};
        w_d        = w_pos_ext - w_neg_ext;
        w_sum_next = r_acc + w_d;
        w_last     = (r_cnt == CNT_LAST);
    end

    tnn_act_compare #(
        .ACC_W (ACC_W)
    ) u_act (
        .i_sum    (w_sum_next),
        .i_thr_hi (thr_hi),
        .i_thr_lo (thr_lo),
        .o_act    (w_act)
    );

    // Control FSM with all handshake outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_act   <= ACT_ZERO;
            r_out_sum   <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid && r_in_ready) begin
                        if (w_last) begin
                            r_acc       <= '0;
                            r_cnt       <= '0;
                            r_out_sum   <= w_sum_next;
                            r_out_act   <= w_act;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= ST_EMIT;
                        end else begin
                            r_acc <= w_sum_next;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    // Result holds until the sink takes it; input reopens next cycle
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_act   = r_out_act;
    assign out_sum   = r_out_sum;

endmodule

// File: tb/tb_ternary_neuron_accum.sv
// Directed self-checking bench for ternary_neuron_accum at CHUNKS=4, PC_W=5, ACC_W=8.
module tb_ternary_neuron_accum;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic        [4:0] pc_pos = 5'd0;
    logic        [4:0] pc_neg = 5'd0;
    logic signed [7:0] thr_hi = 8'sd5;
    logic signed [7:0] thr_lo = -8'sd5;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic        [1:0] out_act;
    logic signed [7:0] out_sum;

    int err_cnt = 0;
    int chk_cnt = 0;

    ternary_neuron_accum #(
        .CHUNKS (4),
        .PC_W   (5),
        .PC_MAX (25),
        .ACC_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc_pos    (pc_pos),
        .pc_neg    (pc_neg),
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_act   (out_act),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int obs, input int exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One chunk handshake; returns #1 after the accepting edge
    task automatic send_chunk(input logic [4:0] p, input logic [4:0] n);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) chk_eq("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        pc_pos   = p;
        pc_neg   = n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Chunks packed first-chunk-first: {c0,c1,c2,c3}
    task automatic run_neuron(input string tag, input logic [19:0] pos_v, input logic [19:0] neg_v,
                              input int exp_sum, input int exp_act);
        for (int i = 0; i < 3; i++) send_chunk(pos_v[(3-i)*5 +: 5], neg_v[(3-i)*5 +: 5]);
        chk_eq({tag, "_valid_early"}, int'(out_valid), 0);
        send_chunk(pos_v[4:0], neg_v[4:0]);
        chk_eq({tag, "_valid"}, int'(out_valid), 1);
        chk_eq({tag, "_in_ready"}, int'(in_ready), 0);
        chk_eq({tag, "_sum"}, int'(out_sum), exp_sum);
        chk_eq({tag, "_act"}, int'(out_act), exp_act);
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk_eq({tag, "_valid_drop"}, int'(out_valid), 0);
        chk_eq({tag, "_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_in_ready", int'(in_ready), 1);
        chk_eq("rst_out_valid", int'(out_valid), 0);
        chk_eq("rst_out_act", int'(out_act), 0);
        chk_eq("rst_out_sum", int'(out_sum), 0);
        rst = 1'b0;

        // T1: 8 + 4 + 0 - 2 = 10
        run_neuron("t1", {5'd10, 5'd7, 5'd0, 5'd4}, {5'd2, 5'd3, 5'd0, 5'd6}, 10, 1);
        consume("t1");

        // T2: all negative, then balanced
        run_neuron("t2a", {4{5'd0}}, {4{5'd9}}, -36, 3);
        consume("t2a");
        run_neuron("t2b", {4{5'd3}}, {4{5'd3}}, 0, 0);
        consume("t2b");

        // T3: 31 clamps to 25, 4*25 = 100 fits in 8 signed bits
        run_neuron("t3", {4{5'd31}}, {4{5'd0}}, 100, 1);
        consume("t3");
        run_neuron("t3n", {4{5'd0}}, {4{5'd28}}, -100, 3);
        consume("t3n");

        // Boundaries: sum equal to each threshold
        thr_hi = 8'sd10;
        run_neuron("eq_hi", {5'd10, 5'd7, 5'd0, 5'd4}, {5'd2, 5'd3, 5'd0, 5'd6}, 10, 1);
        consume("eq_hi");
        thr_hi = 8'sd5;
        thr_lo = -8'sd36;
        run_neuron("eq_lo", {4{5'd0}}, {4{5'd9}}, -36, 3);
        consume("eq_lo");
        thr_lo = -8'sd5;

        // T4: sink stalls while upstream keeps offering chunks
        run_neuron("t4", {5'd10, 5'd7, 5'd0, 5'd4}, {5'd2, 5'd3, 5'd0, 5'd6}, 10, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            pc_pos   = 5'd5;
            pc_neg   = 5'd0;
            @(posedge clk);
            #1;
            chk_eq("t4_stall_in_ready", int'(in_ready), 0);
            chk_eq("t4_stall_valid", int'(out_valid), 1);
            chk_eq("t4_stall_sum", int'(out_sum), 10);
            chk_eq("t4_stall_act", int'(out_act), 1);
        end
        in_valid = 1'b0;
        consume("t4");
        run_neuron("t4_next", {4{5'd1}}, {4{5'd0}}, 4, 0);
        consume("t4_next");

        // T5: reset after two chunks discards the partial sum
        send_chunk(5'd9, 5'd0);
        send_chunk(5'd9, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_eq("t5_valid", int'(out_valid), 0);
        chk_eq("t5_in_ready", int'(in_ready), 1);
        run_neuron("t5", {4{5'd5}}, {4{5'd1}}, 16, 1);

        // Reset while a result is pending drops it
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_eq("rst_emit_valid", int'(out_valid), 0);
        chk_eq("rst_emit_sum", int'(out_sum), 0);
        chk_eq("rst_emit_ready", int'(in_ready), 1);

        // T6: overlapping thresholds favour +1
        thr_hi = -8'sd2;
        thr_lo = 8'sd3;
        run_neuron("t6a", {4{5'd1}}, {4{5'd1}}, 0, 1);
        consume("t6a");

        // T6: thresholds taken at the last handshake only
        thr_hi = 8'sd5;
        thr_lo = -8'sd5;
        for (int i = 0; i < 3; i++) send_chunk(5'd2, 5'd0);
        thr_hi = 8'sd100;
        thr_lo = 8'sd10;
        send_chunk(5'd2, 5'd0);
        chk_eq("t6b_valid", int'(out_valid), 1);
        chk_eq("t6b_sum", int'(out_sum), 8);
        chk_eq("t6b_act", int'(out_act), 3);
        consume("t6b");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
